// File: rtl/branch_flag_unit.sv
// Branch resolution and condition-flag holding unit placed after the ALU.
// Resolves J/BRZ/BRN in one cycle and JM through a stalled memory read, then flushes.
module branch_flag_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int WIDTH        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alu_valid,
    input  logic             alu_z,
    input  logic             alu_n,
    input  logic             br_valid,
    input  logic [1:0]       br_op,
    input  logic [WIDTH-1:0] br_target,
    input  logic [WIDTH-1:0] jm_mem_data,
    input  logic             jm_mem_ready,
    output logic             jm_req,
    output logic             stall_o,
    output logic             pc_load,
    output logic [WIDTH-1:0] pc_target,
    output logic             flush_o,
    output logic             z_flag,
    output logic             n_flag
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        JM_WAIT = 2'd1,
        LOAD    = 2'd2,
        SQUASH  = 2'd3
    } state_t;

    localparam logic [1:0] OP_J   = 2'b00;
    localparam logic [1:0] OP_BRZ = 2'b01;
    localparam logic [1:0] OP_BRN = 2'b10;
    localparam logic [1:0] OP_JM  = 2'b11;

    state_t     state;
    logic [2:0] flush_cnt;
    logic       zeff;
    logic       neff;
    logic       taken;

    // A flag-setting op in the same cycle as the branch is forwarded.
    assign zeff  = alu_valid ? alu_z : z_flag;
    assign neff  = alu_valid ? alu_n : n_flag;
    assign taken = (br_op == OP_J) | ((br_op == OP_BRZ) & zeff) |
                   ((br_op == OP_BRN) & neff);

    assign stall_o = (state == JM_WAIT) |
                     ((state == IDLE) & br_valid & (br_op == OP_JM));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            flush_cnt <= 3'd0;
            jm_req    <= 1'b0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            flush_o   <= 1'b0;
            z_flag    <= 1'b0;
            n_flag    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (alu_valid) begin
                        z_flag <= alu_z;
                        n_flag <= alu_n;
                    end
                    if (br_valid) begin
                        if (br_op == OP_JM) begin
                            jm_req <= 1'b1;
                            state  <= JM_WAIT;
                        end else if (taken) begin
                            pc_target <= br_target;
                            pc_load   <= 1'b1;
                            flush_o   <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                end
                JM_WAIT: begin
                    if (jm_mem_ready) begin
                        pc_target <= jm_mem_data;
                        jm_req    <= 1'b0;
                        pc_load   <= 1'b1;
                        flush_o   <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    // The LOAD cycle is the first of the FLUSH_CYCLES flush cycles.
                    pc_load   <= 1'b0;
                    flush_cnt <= 3'(FLUSH_CYCLES - 1);
                    if (FLUSH_CYCLES == 1) begin
                        flush_o <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        state   <= SQUASH;
                    end
                end
                SQUASH: begin
                    if (flush_cnt == 3'd1) begin
                        flush_o <= 1'b0;
                        state   <= IDLE;
                    end
                    flush_cnt <= flush_cnt - 3'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_flag_unit.sv
// Directed bench for branch_flag_unit: flags, forwarding, JM stall, flush length, reset abort.
module tb_branch_flag_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_z, alu_n;
    logic        br_valid;
    logic [1:0]  br_op;
    logic [31:0] br_target, jm_mem_data;
    logic        jm_mem_ready;

    logic        jm_req, stall_o, pc_load, flush_o, z_flag, n_flag;
    logic [31:0] pc_target;
    logic        jm_req1, stall1, pc_load1, flush1, z_flag1, n_flag1;
    logic [31:0] pc_target1;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    branch_flag_unit #(.FLUSH_CYCLES(2), .WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_z(alu_z), .alu_n(alu_n),
        .br_valid(br_valid), .br_op(br_op), .br_target(br_target),
        .jm_mem_data(jm_mem_data), .jm_mem_ready(jm_mem_ready),
        .jm_req(jm_req), .stall_o(stall_o), .pc_load(pc_load), .pc_target(pc_target),
        .flush_o(flush_o), .z_flag(z_flag), .n_flag(n_flag)
    );

    branch_flag_unit #(.FLUSH_CYCLES(1), .WIDTH(32)) u_dut1 (
        .clk(clk), .rst(rst), .alu_valid(alu_valid), .alu_z(alu_z), .alu_n(alu_n),
        .br_valid(br_valid), .br_op(br_op), .br_target(br_target),
        .jm_mem_data(jm_mem_data), .jm_mem_ready(jm_mem_ready),
        .jm_req(jm_req1), .stall_o(stall1), .pc_load(pc_load1), .pc_target(pc_target1),
        .flush_o(flush1), .z_flag(z_flag1), .n_flag(n_flag1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_in();
        alu_valid = 0; alu_z = 0; alu_n = 0;
        br_valid = 0; br_op = 2'b00; br_target = 0;
        jm_mem_ready = 0;
    endtask

    initial begin
        rst = 1; jm_mem_data = 0;
        clear_in();
        tick(); tick();
        rst = 0;
        tick(); tick(); tick();
        check("rst_pc_target", pc_target, 0);
        check("rst_pc_load", pc_load, 0);
        check("rst_flush", flush_o, 0);
        check("rst_jm_req", jm_req, 0);
        check("rst_z", z_flag, 0);
        check("rst_n", n_flag, 0);
        check("rst_stall", stall_o, 0);

        // SUB 5-5 commits: Z=1, N=0; BRZ follows next cycle
        alu_valid = 1; alu_z = 1; alu_n = 0;
        tick();
        clear_in();
        br_valid = 1; br_op = 2'b01; br_target = 32'h40;
        #1;
        check("brz_z_flag", z_flag, 1);
        check("brz_stall", stall_o, 0);
        tick();
        clear_in();
        check("brz_pc_load", pc_load, 1);
        check("brz_pc_target", pc_target, 32'h40);
        check("brz_flush1", flush_o, 1);
        tick();
        check("brz_pc_load_pulse", pc_load, 0);
        check("brz_flush2", flush_o, 1);
        tick();
        check("brz_flush_end", flush_o, 0);

        // SUB 3-7 in the same cycle as BRN: N forwarded
        check("fwd_n_before", n_flag, 0);
        alu_valid = 1; alu_z = 0; alu_n = 1;
        br_valid = 1; br_op = 2'b10; br_target = 32'h80;
        tick();
        clear_in();
        check("fwd_pc_load", pc_load, 1);
        check("fwd_pc_target", pc_target, 32'h80);
        check("fwd_n_after", n_flag, 1);
        check("fwd_z_after", z_flag, 0);
        tick(); tick();
        check("fwd_idle_flush", flush_o, 0);

        // BRZ with Z=0 and no forwarding: not taken
        br_valid = 1; br_op = 2'b01; br_target = 32'h99;
        #1;
        check("nt_stall", stall_o, 0);
        tick();
        clear_in();
        check("nt_pc_load", pc_load, 0);
        check("nt_flush", flush_o, 0);
        check("nt_pc_target", pc_target, 32'h80);
        tick();
        check("nt_pc_load2", pc_load, 0);

        // JM: memory ready in the 4th wait cycle
        br_valid = 1; br_op = 2'b11; br_target = 32'hdead; jm_mem_data = 32'h1234;
        #1;
        check("jm_stall_br", stall_o, 1);
        check("jm_req_br", jm_req, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            clear_in();
            if (i == 3) jm_mem_ready = 1;
            #1;
            check("jm_wait_req", jm_req, 1);
            check("jm_wait_stall", stall_o, 1);
            check("jm_wait_pc_load", pc_load, 0);
        end
        tick();
        clear_in();
        #1;
        check("jm_pc_load", pc_load, 1);
        check("jm_pc_target", pc_target, 32'h1234);
        check("jm_req_done", jm_req, 0);
        check("jm_stall_done", stall_o, 0);
        check("jm_flush", flush_o, 1);
        tick(); tick();
        check("jm_idle_flush", flush_o, 0);

        // Reset asserted mid-SQUASH aborts the flush
        br_valid = 1; br_op = 2'b00; br_target = 32'h50;
        tick();
        clear_in();
        check("rsq_load", pc_load, 1);
        tick();
        check("rsq_squash_flush", flush_o, 1);
        rst = 1;
        tick();
        rst = 0;
        check("rsq_flush", flush_o, 0);
        check("rsq_pc_load", pc_load, 0);
        check("rsq_pc_target", pc_target, 0);
        tick();

        // FLUSH_CYCLES=1 instance: second J during LOAD is ignored
        br_valid = 1; br_op = 2'b00; br_target = 32'h10;
        tick();
        br_target = 32'h20;
        check("f1_pc_load", pc_load1, 1);
        check("f1_pc_target", pc_target1, 32'h10);
        check("f1_flush", flush1, 1);
        tick();
        clear_in();
        check("f1_pc_load_end", pc_load1, 0);
        check("f1_flush_end", flush1, 0);
        check("f1_pc_target_hold", pc_target1, 32'h10);
        tick();
        check("f1_no_second_load", pc_load1, 0);
        check("f1_pc_target_final", pc_target1, 32'h10);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/branch_flag_unit.md
Name: branch_flag_unit

Overview:
- Sits directly downstream of the ALU in the processor datapath.
- Holds the ALU Z/N condition flags across cycles and resolves J, BRZ, BRN and JM (jump via memory) branches against those flags.
- Drives the PC load/target and the pipeline flush/stall controls.
- JM is multi-cycle: the unit stalls the pipeline until the data-memory read of the target returns.

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_o stays high after a taken branch; legal range 1 to 7.
- WIDTH, 32, width of the datapath, branch target and memory data.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- alu_valid  input  1  an ALU op (ADD/INC/NEG/SUB) commits this cycle; qualifies alu_z/alu_n.
- alu_z  input  1  Z output of the ALU (result == 0).
- alu_n  input  1  N output of the ALU (result bit 31).
- br_valid  input  1  a branch instruction is resolving this cycle.
- br_op  input  2  00=J, 01=BRZ, 10=BRN, 11=JM.
- br_target  input  WIDTH  register-file value: jump target for J/BRZ/BRN; ignored for JM.
- jm_mem_data  input  WIDTH  data-memory read data holding the JM target.
- jm_mem_ready  input  1  jm_mem_data is valid this cycle.
- jm_req  output  1  registered; data-memory read request for JM.
- stall_o  output  1  freezes upstream stages.
- pc_load  output  1  registered one-cycle pulse; PC takes pc_target.
- pc_target  output  WIDTH  registered new PC value; valid when pc_load=1.
- flush_o  output  1  registered; squashes younger in-flight instructions.
- z_flag  output  1  registered stored Z flag.
- n_flag  output  1  registered stored N flag.

Behaviour:
- Reset:
  - All outputs are 0; pc_target=0; state=IDLE; flush counter=0.
  - A reset asserted in any state, including mid-JM_WAIT or mid-SQUASH, aborts the operation with no pc_load.
- Flags:
  - In IDLE, alu_valid=1 loads z_flag<=alu_z and n_flag<=alu_n at the next edge.
  - alu_valid is ignored in JM_WAIT and SQUASH; the flags hold.
- Effective flags for branch evaluation:
  - zeff = alu_valid ? alu_z : z_flag, and likewise neff.
  - This forwards an ALU op committing in the same cycle as the branch.
- States: IDLE, JM_WAIT, LOAD, SQUASH.
- IDLE, br_valid=1:
  - Taken when J, or BRZ with zeff=1, or BRN with neff=1. The next edge latches pc_target<=br_target and moves to LOAD.
  - Not taken: stay in IDLE; no outputs change other than the flags.
  - JM: stall_o=1 combinationally in this same cycle. The next edge sets jm_req<=1 and moves to JM_WAIT.
- JM_WAIT:
  - stall_o=1; jm_req stays 1.
  - When jm_mem_ready=1: pc_target<=jm_mem_data, jm_req<=0, move to LOAD.
  - No timeout; the state waits indefinitely.
- LOAD (exactly 1 cycle):
  - pc_load=1 and flush_o=1; counter<=FLUSH_CYCLES-1.
  - If FLUSH_CYCLES=1, return to IDLE; otherwise go to SQUASH.
- SQUASH:
  - flush_o=1; counter decrements each cycle; exit to IDLE on the edge where counter==1.
  - flush_o is therefore high for exactly FLUSH_CYCLES cycles, starting with the pc_load cycle.
- br_valid is ignored outside IDLE; the instruction is squashed or stalled.
- stall_o = (state==JM_WAIT) | (state==IDLE & br_valid & br_op==11). No other output is combinational.
- Latency, taken J/BRZ/BRN: pc_load appears 1 cycle after br_valid.
- Latency, JM: pc_load appears 1 cycle after the jm_mem_ready cycle. If ready comes in the first JM_WAIT cycle, pc_load is 2 cycles after br_valid.
- pc_target holds its value between loads.

Test Plan:
- Reset, then idle 3 cycles -> all outputs 0 and state IDLE; assert rst during SQUASH -> next cycle flush_o=0, pc_load=0.
- SUB committing with alu_z=1, alu_n=0 (ALU computes a-b, e.g. a=5,b=5), next cycle BRZ with br_target=0x40 -> z_flag=1; pc_load=1 with pc_target=0x40 one cycle later; flush_o high 2 cycles.
- Same-cycle alu_valid=1, alu_n=1 (ALU computes a-b, e.g. a=3,b=7) while n_flag=0, with BRN target 0x80 -> forwarded flag makes branch taken; pc_target=0x80; n_flag=1 afterwards.
- BRZ with z_flag=0 and alu_valid=0 -> no pc_load, no flush, no stall, state stays IDLE.
- JM with memory ready after 3 wait cycles and data 0x1234 -> stall_o high from the br_valid cycle through the ready cycle (5 cycles); jm_req high for the 4 JM_WAIT cycles; pc_load=1 with pc_target=0x1234 the cycle after ready.
- FLUSH_CYCLES=1, J to 0x10 followed by br_valid J to 0x20 during LOAD -> second branch ignored; flush_o exactly 1 cycle; pc_target remains 0x10.
